// File: rtl/prediction_accuracy_monitor_if.sv
// Sample/statistics bundle between the predictor-side driver and the accuracy monitor.
// The driver presents outcome samples; the monitor returns its registered statistics.
interface prediction_accuracy_monitor_if #(
  parameter int CNT_W = 8,
  parameter int WIN   = 8
);
  localparam int WM_W = $clog2(WIN + 1);

  logic             valid;
  logic             actual_bit;
  logic             predicted_bit;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [WM_W-1:0]  win_miss;
  logic [CNT_W-1:0] cur_streak;
  logic [CNT_W-1:0] best_streak;
  logic             alarm;
  logic [1:0]       state;

  modport master (
    output valid, actual_bit, predicted_bit,
    input  total_cnt, hit_cnt, miss_cnt, win_miss, cur_streak, best_streak, alarm, state
  );

  modport slave (
    input  valid, actual_bit, predicted_bit,
    output total_cnt, hit_cnt, miss_cnt, win_miss, cur_streak, best_streak, alarm, state
  );
endinterface

// File: rtl/prediction_accuracy_monitor.sv
// Scoreboard for the 2-bit predictor: saturating hit/miss statistics, hit streaks,
// a sliding miss window and a hysteretic accuracy alarm. All outputs are registered.
module prediction_accuracy_monitor #(
  parameter int CNT_W    = 8,
  parameter int WIN      = 8,
  parameter int ALARM_TH = 4,
  parameter int CLR_TH   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  prediction_accuracy_monitor_if.slave mon
);

  localparam int WM_W = $clog2(WIN + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WM_W-1:0]  ALARM_LVL = WM_W'(ALARM_TH);
  localparam logic [WM_W-1:0]  CLR_LVL   = WM_W'(CLR_TH);
  localparam logic [WM_W-1:0]  FILL_LAST = WM_W'(WIN - 1);
  localparam logic [WM_W-1:0]  FILL_FULL = WM_W'(WIN);

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    TRACK   = 2'd1,
    ALARM   = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] total_q, hit_q, miss_q, cur_q, best_q;
  logic [WIN-1:0]   win_q;
  logic [WM_W-1:0]  win_miss_q;
  logic [WM_W-1:0]  fill_q;
  state_e           state_q;
  logic             alarm_q;

  logic             sample_miss;
  logic [WIN-1:0]   win_next;
  logic [WM_W-1:0]  win_miss_next;
  logic [CNT_W-1:0] total_next, hit_next, miss_next, cur_next, best_next;
  logic [WM_W-1:0]  fill_next;

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    sample_miss   = (mon.actual_bit != mon.predicted_bit);
    win_next      = {win_q[WIN-2:0], sample_miss};
    win_miss_next = win_miss_q + WM_W'(sample_miss) - WM_W'(win_q[WIN-1]);
    total_next    = sat_inc(total_q);
    hit_next      = hit_q;
    miss_next     = miss_q;
    cur_next      = '0;
    if (sample_miss) begin
      miss_next = sat_inc(miss_q);
    end else begin
      hit_next  = sat_inc(hit_q);
      cur_next  = sat_inc(cur_q);
    end
    best_next = (cur_next > best_q) ? cur_next : best_q;
    fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + WM_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      cur_q      <= '0;
      best_q     <= '0;
      // NOTE: the miss window is reset even though it is storage, because win_miss is
      // maintained incrementally and is only equal to popcount(window) from a known start.
      win_q      <= '0;
      win_miss_q <= '0;
      fill_q     <= '0;
      state_q    <= WARMUP;
      alarm_q    <= 1'b0;
    end else begin
      if (mon.valid) begin
        total_q    <= total_next;
        hit_q      <= hit_next;
        miss_q     <= miss_next;
        cur_q      <= cur_next;
        best_q     <= best_next;
        win_q      <= win_next;
        win_miss_q <= win_miss_next;
        fill_q     <= fill_next;
      end

      // Hysteresis: levels strictly between CLR_TH and ALARM_TH keep the current state.
      case (state_q)
        WARMUP: begin
          if (mon.valid && fill_q == FILL_LAST) begin
            if (win_miss_next >= ALARM_LVL) begin
              state_q <= ALARM;
              alarm_q <= 1'b1;
            end else begin
              state_q <= TRACK;
              alarm_q <= 1'b0;
            end
          end
        end
        TRACK: begin
          if (mon.valid && win_miss_next >= ALARM_LVL) begin
            state_q <= ALARM;
            alarm_q <= 1'b1;
          end
        end
        ALARM: begin
          if (mon.valid && win_miss_next <= CLR_LVL) begin
            state_q <= TRACK;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q <= WARMUP;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign mon.total_cnt   = total_q;
  assign mon.hit_cnt     = hit_q;
  assign mon.miss_cnt    = miss_q;
  assign mon.win_miss    = win_miss_q;
  assign mon.cur_streak  = cur_q;
  assign mon.best_streak = best_q;
  assign mon.alarm       = alarm_q;
  assign mon.state       = state_q;

endmodule

// File: tb/tb_prediction_accuracy_monitor.sv
// Bench for prediction_accuracy_monitor: two instances (CNT_W=8 and CNT_W=4) share stimulus
// and are compared every cycle against an outcome-history model, plus literal spot checks.
module tb_prediction_accuracy_monitor;

  localparam int WIN      = 8;
  localparam int ALARM_TH = 4;
  localparam int CLR_TH   = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prediction_accuracy_monitor_if #(.CNT_W(8), .WIN(WIN)) bus8 ();
  prediction_accuracy_monitor_if #(.CNT_W(4), .WIN(WIN)) bus4 ();

  prediction_accuracy_monitor #(.CNT_W(8), .WIN(WIN), .ALARM_TH(ALARM_TH), .CLR_TH(CLR_TH)) dut8 (
    .clk   (clk),
    .reset (reset),
    .mon   (bus8.slave)
  );

  prediction_accuracy_monitor #(.CNT_W(4), .WIN(WIN), .ALARM_TH(ALARM_TH), .CLR_TH(CLR_TH)) dut4 (
    .clk   (clk),
    .reset (reset),
    .mon   (bus4.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Unbounded "true" statistics; saturation is applied when comparing.
  bit hist[$];
  int m_total, m_hit, m_miss, m_cur, m_best, m_state;
  bit tgl = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cap(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int model_wm();
    int n = 0;
    foreach (hist[i]) n += int'(hist[i]);
    return n;
  endfunction

  task automatic model_update(input bit r, input bit v, input bit a, input bit p);
    bit miss;
    int wm;
    if (r) begin
      m_total = 0; m_hit = 0; m_miss = 0; m_cur = 0; m_best = 0; m_state = 0;
      hist.delete();
    end else if (v) begin
      miss = (a != p);
      m_total++;
      if (miss) begin
        m_miss++;
        m_cur = 0;
      end else begin
        m_hit++;
        m_cur++;
      end
      if (m_cur > m_best) m_best = m_cur;
      hist.push_back(miss);
      if (hist.size() > WIN) void'(hist.pop_front());
      wm = model_wm();
      case (m_state)
        0: if (m_total == WIN) m_state = (wm >= ALARM_TH) ? 2 : 1;
        1: if (wm >= ALARM_TH) m_state = 2;
        2: if (wm <= CLR_TH) m_state = 1;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic cmp_dut(input string pfx, input int w, input int total, input int hit,
                         input int miss, input int wm, input int cur, input int best,
                         input int al, input int st);
    check({pfx, ".total_cnt"},   total, cap(m_total, w));
    check({pfx, ".hit_cnt"},     hit,   cap(m_hit, w));
    check({pfx, ".miss_cnt"},    miss,  cap(m_miss, w));
    check({pfx, ".win_miss"},    wm,    model_wm());
    check({pfx, ".cur_streak"},  cur,   cap(m_cur, w));
    check({pfx, ".best_streak"}, best,  cap(m_best, w));
    check({pfx, ".state"},       st,    m_state);
    check({pfx, ".alarm"},       al,    (m_state == 2) ? 1 : 0);
  endtask

  task automatic step(input bit r, input bit v, input bit a, input bit p);
    reset              = r;
    bus8.valid         = v;
    bus8.actual_bit    = a;
    bus8.predicted_bit = p;
    bus4.valid         = v;
    bus4.actual_bit    = a;
    bus4.predicted_bit = p;
    @(posedge clk);
    model_update(r, v, a, p);
    @(negedge clk);
    cmp_dut("d8", 8, int'(bus8.total_cnt), int'(bus8.hit_cnt), int'(bus8.miss_cnt),
            int'(bus8.win_miss), int'(bus8.cur_streak), int'(bus8.best_streak),
            int'(bus8.alarm), int'(bus8.state));
    cmp_dut("d4", 4, int'(bus4.total_cnt), int'(bus4.hit_cnt), int'(bus4.miss_cnt),
            int'(bus4.win_miss), int'(bus4.cur_streak), int'(bus4.best_streak),
            int'(bus4.alarm), int'(bus4.state));
  endtask

  // Hit and miss samples alternate the underlying bit values so both encodings are exercised.
  task automatic do_hit();
    tgl = ~tgl;
    step(1'b0, 1'b1, tgl, tgl);
  endtask

  task automatic do_miss();
    tgl = ~tgl;
    step(1'b0, 1'b1, tgl, ~tgl);
  endtask

  task automatic do_idle();
    tgl = ~tgl;
    step(1'b0, 1'b0, tgl, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // 1. Reset, then idle cycles with noisy inputs.
    do_reset();
    do_reset();
    check("t1.reset_total", int'(bus8.total_cnt), 0);
    check("t1.reset_state", int'(bus8.state), 0);
    repeat (5) do_idle();
    check("t1.idle_total", int'(bus8.total_cnt), 0);
    check("t1.idle_win",   int'(bus8.win_miss), 0);

    // 2. Eight hits fill the window and leave warm-up.
    repeat (8) do_hit();
    check("t2.total", int'(bus8.total_cnt), 8);
    check("t2.best",  int'(bus8.best_streak), 8);
    check("t2.state", int'(bus8.state), 1);
    check("t2.alarm", int'(bus8.alarm), 0);

    // 3. Four misses raise the alarm.
    repeat (3) do_miss();
    check("t3.state_after3", int'(bus8.state), 1);
    do_miss();
    check("t3.miss",  int'(bus8.miss_cnt), 4);
    check("t3.win",   int'(bus8.win_miss), 4);
    check("t3.cur",   int'(bus8.cur_streak), 0);
    check("t3.alarm", int'(bus8.alarm), 1);

    // 4. Hits drain the window; alarm clears once win_miss reaches CLR_TH.
    repeat (4) do_hit();
    check("t4.win_hit4", int'(bus8.win_miss), 4);
    do_hit();
    check("t4.win_hit5", int'(bus8.win_miss), 3);
    do_hit();
    check("t4.state_hit6", int'(bus8.state), 2);
    do_hit();
    check("t4.win_hit7",   int'(bus8.win_miss), 1);
    check("t4.state_hit7", int'(bus8.state), 1);
    check("t4.best_hit7",  int'(bus8.best_streak), 8);
    repeat (3) do_hit();
    check("t4.best_hit10", int'(bus8.best_streak), 10);

    // Hysteresis band: alternating outcomes hover between the thresholds.
    repeat (3) begin
      do_miss();
      do_hit();
    end
    repeat (2) do_miss();
    do_idle();
    repeat (3) do_hit();

    // 5. Warm-up suppresses the alarm until the window is full.
    do_reset();
    repeat (5) do_miss();
    check("t5.win_s5",   int'(bus8.win_miss), 5);
    check("t5.alarm_s5", int'(bus8.alarm), 0);
    repeat (2) do_hit();
    check("t5.state_s7", int'(bus8.state), 0);
    do_hit();
    check("t5.win_s8",   int'(bus8.win_miss), 5);
    check("t5.state_s8", int'(bus8.state), 2);

    // 6. Saturation of the narrow instance with gapped samples.
    do_reset();
    repeat (20) begin
      do_hit();
      do_idle();
    end
    check("t6.d4_total", int'(bus4.total_cnt), 15);
    check("t6.d4_hit",   int'(bus4.hit_cnt), 15);
    check("t6.d4_cur",   int'(bus4.cur_streak), 15);
    check("t6.d4_best",  int'(bus4.best_streak), 15);
    check("t6.d8_total", int'(bus8.total_cnt), 20);

    // Reset while in ALARM.
    do_reset();
    repeat (8) do_hit();
    repeat (4) do_miss();
    check("t6.pre_alarm", int'(bus8.alarm), 1);
    do_reset();
    check("t6.rst_alarm", int'(bus8.alarm), 0);
    check("t6.rst_state", int'(bus8.state), 0);
    check("t6.rst_total", int'(bus8.total_cnt), 0);
    check("t6.rst_win",   int'(bus8.win_miss), 0);
    check("t6.rst_best",  int'(bus4.best_streak), 0);
    repeat (2) do_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
